// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between the core's load/store path and
// the data-memory responder.
//   master (core)      : drives req_valid/req_we/req_addr/req_wdata/req_size/
//                        req_unsigned and rsp_ready
//   slave  (responder) : drives req_ready, rsp_valid, rsp_rdata and rsp_err
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with a valid/ready handshake,
// LATENCY wait states and a word-organised RAM of DEPTH 32-bit words.
// Handles byte/half/word loads (sign or zero extended) and stores; flags
// misaligned, out-of-range and illegal-size requests on rsp_err.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous, active-high
//   bus    - dmem_if.slave: req_* request channel, rsp_* response channel
//
// state | meaning
// IDLE  | req_ready=1, accepts a request; stores commit on the accept edge
// WAIT  | wait-state down-counter running, terminal count 0 moves to RESP
// RESP  | rsp_valid=1, rdata/err held until rsp_ready
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nx;

  logic [31:0] mem [DEPTH];

  logic [3:0]    cnt;
  logic          we_q;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic          rsp_err_q;

  logic          accept;
  logic          err_c;
  logic          wr_en;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;

  logic          e_we;
  logic [AW+1:0] e_addr;
  logic [1:0]    e_size;
  logic          e_uns;
  logic          e_err;
  logic [31:0]   word_rd;
  logic [7:0]    b_sel;
  logic [15:0]   h_sel;
  logic [31:0]   ld;

  assign accept = (state == IDLE) && bus.req_valid && !reset;

  // DEPTH is a power of two, so "addr >= DEPTH*4" is any upper bit set.
  always_comb begin
    err_c = 1'b0;
    case (bus.req_size)
      2'b01:   err_c = bus.req_addr[0];
      2'b10:   err_c = (bus.req_addr[1:0] != 2'b00);
      2'b11:   err_c = 1'b1;
      default: err_c = 1'b0;
    endcase
    if (|bus.req_addr[31:AW+2]) err_c = 1'b1;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.req_valid) state_nx = (LATENCY > 0) ? WAIT : RESP;
      WAIT: if (cnt == 4'd0)   state_nx = RESP;
      RESP: if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // ---------------------------------------------------------------- stores
  always_comb begin
    be        = 4'b0000;
    wdata_rep = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        be        = 4'b0001 << bus.req_addr[1:0];
        wdata_rep = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be        = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.req_wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  assign wr_en = accept && bus.req_we && !err_c;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[bus.req_addr[AW+1:2]][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- loads
  // With LATENCY=0 RESP is entered on the accept edge itself, so the load
  // path uses the live request fields in IDLE and the captured ones after.
  always_comb begin
    if (state == IDLE) begin
      e_we   = bus.req_we;
      e_addr = bus.req_addr[AW+1:0];
      e_size = bus.req_size;
      e_uns  = bus.req_unsigned;
      e_err  = err_c;
    end else begin
      e_we   = we_q;
      e_addr = addr_q;
      e_size = size_q;
      e_uns  = uns_q;
      e_err  = err_q;
    end
  end

  always_comb begin
    word_rd = mem[e_addr[AW+1:2]];
    case (e_addr[1:0])
      2'b00:   b_sel = word_rd[7:0];
      2'b01:   b_sel = word_rd[15:8];
      2'b10:   b_sel = word_rd[23:16];
      default: b_sel = word_rd[31:24];
    endcase
    h_sel = e_addr[1] ? word_rd[31:16] : word_rd[15:0];
    case (e_size)
      2'b00:   ld = e_uns ? {24'd0, b_sel} : {{24{b_sel[7]}}, b_sel};
      2'b01:   ld = e_uns ? {16'd0, h_sel} : {{16{h_sel[15]}}, h_sel};
      default: ld = word_rd;
    endcase
    if (e_we || e_err) ld = 32'd0;
  end

  // ---------------------------------------------------------------- datapath
  // wdata is not retained: stores are committed on the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        we_q   <= bus.req_we;
        addr_q <= bus.req_addr[AW+1:0];
        size_q <= bus.req_size;
        uns_q  <= bus.req_unsigned;
        err_q  <= err_c;
        if (LATENCY > 0) cnt <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (state_nx == RESP && state != RESP) begin
        rdata_q   <= ld;
        rsp_err_q <= e_err;
      end else if (state == RESP && bus.rsp_ready) begin
        rdata_q   <= 32'd0;
        rsp_err_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder with LATENCY=2 (main
// instance) and LATENCY=0 (small instance, rsp_ready tied high).
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dmem_if bus ();
  dmem_if bus0 ();

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dmem_responder #(.DEPTH(16), .LATENCY(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
  endtask

  // Waits for rsp_valid; n counts cycles after the accept cycle.
  task automatic wait_rsp(input string tag);
    int n;
    n = 1;
    while (!bus.rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd3);
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                      input logic [31:0] exp_data, input logic exp_err);
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
    drive(we, addr, wdata, size, uns);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    wait_rsp(tag);
    chk({tag, "_data"}, bus.rsp_rdata, exp_data);
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  // LATENCY=0 request table
  logic        t_we   [6];
  logic [31:0] t_addr [6];
  logic [31:0] t_wd   [6];
  logic [1:0]  t_size [6];
  logic        t_uns  [6];
  logic [31:0] t_exp  [6];
  logic        t_err  [6];

  initial begin
    t_we[0]=1; t_addr[0]=32'h8;  t_wd[0]=32'hA5A55A5A; t_size[0]=2'b10; t_uns[0]=0; t_exp[0]=32'h0;        t_err[0]=0;
    t_we[1]=0; t_addr[1]=32'h8;  t_wd[1]=32'h0;        t_size[1]=2'b10; t_uns[1]=0; t_exp[1]=32'hA5A55A5A; t_err[1]=0;
    t_we[2]=0; t_addr[2]=32'hB;  t_wd[2]=32'h0;        t_size[2]=2'b00; t_uns[2]=1; t_exp[2]=32'h000000A5; t_err[2]=0;
    t_we[3]=0; t_addr[3]=32'h8;  t_wd[3]=32'h0;        t_size[3]=2'b01; t_uns[3]=0; t_exp[3]=32'h00005A5A; t_err[3]=0;
    t_we[4]=0; t_addr[4]=32'h40; t_wd[4]=32'h0;        t_size[4]=2'b10; t_uns[4]=0; t_exp[4]=32'h0;        t_err[4]=1;
    t_we[5]=0; t_addr[5]=32'hA;  t_wd[5]=32'h0;        t_size[5]=2'b01; t_uns[5]=0; t_exp[5]=32'hFFFFA5A5; t_err[5]=0;
  end

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0;  bus.rsp_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    bus0.req_valid = 1'b0; bus0.rsp_ready = 1'b1;
    bus0.req_we = 1'b0; bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
    bus0.req_size = 2'b10; bus0.req_unsigned = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);

    // word write/read
    xact("st_w10", 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0);
    xact("ld_w10", 0, 32'h10, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0);

    // byte/half lanes and extension
    xact("st_w20", 1, 32'h20, 32'h0, 2'b10, 0, 32'h0, 0);
    xact("st_b21", 1, 32'h21, 32'hAAAAAA80, 2'b00, 0, 32'h0, 0);
    xact("ld_b21s", 0, 32'h21, 32'h0, 2'b00, 0, 32'hFFFFFF80, 0);
    xact("ld_b21u", 0, 32'h21, 32'h0, 2'b00, 1, 32'h00000080, 0);
    xact("ld_h20s", 0, 32'h20, 32'h0, 2'b01, 0, 32'hFFFF8000, 0);
    xact("st_h22", 1, 32'h22, 32'h1234CAFE, 2'b01, 0, 32'h0, 0);
    xact("ld_w20", 0, 32'h20, 32'h0, 2'b10, 0, 32'hCAFE8000, 0);
    xact("ld_h22u", 0, 32'h22, 32'h0, 2'b01, 1, 32'h0000CAFE, 0);
    xact("ld_b23s", 0, 32'h23, 32'h0, 2'b00, 0, 32'hFFFFFFCA, 0);
    xact("ld_b20u", 0, 32'h20, 32'h0, 2'b00, 1, 32'h00000000, 0);

    // errors and range boundary
    xact("ld_w13", 0, 32'h13, 32'h0, 2'b10, 0, 32'h0, 1);
    xact("st_h11", 1, 32'h11, 32'h0000FFFF, 2'b01, 0, 32'h0, 1);
    xact("ld_w1000", 0, 32'h1000, 32'h0, 2'b10, 0, 32'h0, 1);
    xact("ld_sz3", 0, 32'h10, 32'h0, 2'b11, 0, 32'h0, 1);
    xact("st_w0", 1, 32'h0, 32'h11111111, 2'b10, 0, 32'h0, 0);
    xact("st_w1000", 1, 32'h1000, 32'h99999999, 2'b10, 0, 32'h0, 1);
    xact("ld_w0", 0, 32'h0, 32'h0, 2'b10, 0, 32'h11111111, 0);
    xact("st_wffc", 1, 32'hFFC, 32'h76543210, 2'b10, 0, 32'h0, 0);
    xact("ld_wffc", 0, 32'hFFC, 32'h0, 2'b10, 0, 32'h76543210, 0);
    xact("ld_w10b", 0, 32'h10, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0);

    // backpressure with a competing request held during RESP
    drive(0, 32'h10, 32'h0, 2'b10, 0);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    wait_rsp("bp");
    drive(1, 32'h10, 32'h0BADF00D, 2'b10, 0);
    bus.req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("bp_idle_ready", 32'(bus.req_ready), 32'd1);
    chk("bp_idle_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    bus.req_valid = 1'b0;
    chk("bp_accepted", 32'(bus.req_ready), 32'd0);
    wait_rsp("bp_st");
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    xact("ld_after_bp", 0, 32'h10, 32'h0, 2'b10, 0, 32'h0BADF00D, 0);

    // LATENCY=0 back-to-back, rsp_ready high
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) begin
        bus0.req_we       = t_we[k/2];
        bus0.req_addr     = t_addr[k/2];
        bus0.req_wdata    = t_wd[k/2];
        bus0.req_size     = t_size[k/2];
        bus0.req_unsigned = t_uns[k/2];
        bus0.req_valid    = 1'b1;
        chk("l0_req_ready", 32'(bus0.req_ready), 32'd1);
        chk("l0_rsp_idle", 32'(bus0.rsp_valid), 32'd0);
      end else begin
        chk("l0_busy", 32'(bus0.req_ready), 32'd0);
        chk("l0_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
        chk("l0_rdata", bus0.rsp_rdata, t_exp[k/2]);
        chk("l0_err", 32'(bus0.rsp_err), 32'(t_err[k/2]));
      end
      tick();
    end
    bus0.req_valid = 1'b0;

    // reset during WAIT of a load
    drive(0, 32'h10, 32'h0, 2'b10, 0);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rl_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rl_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    chk("rl_discarded", 32'(bus.rsp_valid), 32'd0);

    // reset during WAIT of a store; the write stays committed
    drive(1, 32'h40, 32'h12345678, 2'b10, 0);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rs_req_ready", 32'(bus.req_ready), 32'd1);
    xact("ld_w40", 0, 32'h40, 32'h0, 2'b10, 0, 32'h12345678, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
